alu_host_seq: RTL and testbench
===============================

Name: alu_host_seq

Overview:
- Upstream sequencer for the 8-bit ALU/multiplier wrapper.
- Accepts a 3-byte host transaction (Cmd, A, B) on a valid/ready byte stream.
- Drives the wrapper's shared 8-bit operand/command bus and its LoadA/LoadB/LoadCmd strobes on an exact cycle schedule.
- Captures the two result bytes around Done and returns them as one 16-bit result word with valid/ready handshake.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles spent in S_WAIT for Done_i; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  host byte valid
- in_data  in  8  host byte; order within a transaction is Cmd, A, B
- in_ready  out  1  byte accepted on edge when in_valid && in_ready
- res_valid  out  1  result word valid
- res_data  out  16  {hi, lo}: MUL gives product[15:0]; otherwise {flags byte, ALU result}
- res_err  out  1  timeout flag, qualified by res_valid
- res_ready  in  1  host accepts result
- ABCmd_o  out  8  bus to wrapper ABCmd_i
- LoadA_o  out  1  to wrapper LoadA_i
- LoadB_o  out  1  to wrapper LoadB_i
- LoadCmd_o  out  1  to wrapper LoadCmd_i
- ACC_i  in  8  from wrapper ACC_o
- Done_i  in  1  from wrapper Done_o
- busy  out  1  high in every state except S_IDLE

Behaviour:
- Reset: state S_IDLE; ABCmd_o=0x00; all Load*_o=0; res_valid=0; res_data=0x0000; res_err=0; in_ready=1; busy=0.
- All Load*_o and ABCmd_o are registered, decoded from state plus the held rCmd/rA/rB registers.
- Only one Load*_o is ever high in any cycle.
- States and transitions:
  - S_IDLE: in_ready=1. On an accepted byte, rCmd<=in_data, go to S_GETA.
  - S_GETA: in_ready=1. On an accepted byte, rA<=in_data, go to S_GETB.
  - S_GETB: in_ready=1. On an accepted byte, rB<=in_data, go to S_DRVA.
  - Gaps in in_valid are tolerated; the state is held.
  - S_DRVA: ABCmd_o=rA, LoadA_o=1. Next state S_DRVB.
  - S_DRVB: ABCmd_o=rA (wrapper latches A this cycle), LoadB_o=1. Next state S_DRVC.
  - S_DRVC: ABCmd_o=rB (wrapper latches B), LoadCmd_o=1. Next state S_EXEC.
  - S_EXEC: ABCmd_o=rCmd (wrapper computes low byte). Next state S_WAIT.
  - S_WAIT: ABCmd_o=rCmd. On Done_i=1, lo<=ACC_i and go to S_CAPHI. Otherwise remain.
  - S_CAPHI: ABCmd_o=rCmd. hi<=ACC_i, go to S_OUT.
  - S_OUT: res_valid=1; res_data={hi,lo} stable. On res_ready, go to S_IDLE.
- ABCmd_o holds rCmd from S_EXEC through S_OUT and S_IDLE, until the next S_DRVA.
- Latency: with a compliant wrapper, Done_i arrives in the first S_WAIT cycle. res_valid rises 7 cycles after the edge accepting B.
- in_ready=0 from S_DRVA through S_OUT; there is no overlap of transactions.
- Done_i outside S_WAIT is ignored.
- res_valid && !res_ready: res_data and res_err are held indefinitely.
- Asynchronous reset in any state aborts the transaction immediately. Partial bytes are discarded; Load*_o drop low.
- No width extension: hi and lo are raw wrapper bytes.

Optional Feature:
- Macro: ALU_HOST_SEQ_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on entry to S_WAIT and increments each S_WAIT cycle.
  - If TIMEOUT_CYCLES cycles elapse without Done_i, set res_err=1, res_data=0x0000, and go directly to S_OUT.
  - res_err clears on the next accepted Cmd byte.
- Undefined: S_WAIT waits indefinitely; res_err is tied 0; no counter logic.

Decomposition:
- Package alu_host_seq_pkg holds:
  - state encoding constants
  - Cmd bit positions: MUL=7, BCD=6, SHR=5, CI=4, OP=3:0
  - TXN_BYTES=3
  - flags byte layout {000,CO,V,Z,N,HC}
- One natural sub-module: alu_host_seq_rx, the 3-byte collector with in_valid/in_ready, emitting {rCmd,rA,rB} plus a one-cycle txn_go.
- The drive/capture FSM stays in the top.

Test Plan:
- Reset: assert reset mid-S_DRVB -> all Load*_o=0, ABCmd_o=0x00, in_ready=1, res_valid=0 the same cycle.
- MUL small: bytes 0x80, 0x0C, 0x0A with the wrapper attached -> res_data=0x0078, res_err=0. Also check the bus sequence A,A,B,0x80 with LoadA, LoadB, LoadCmd in consecutive cycles.
- MUL max: bytes 0x80, 0xFF, 0xFF -> res_data=0xFE01, res_valid 7 cycles after the B-accept edge.
- Backpressure and gaps: in_valid gaps of 3 cycles between bytes and res_ready low for 5 cycles -> transaction correct, res_data stable, in_ready=0 until the handshake.
- Back-to-back: two MUL transactions (0x02*0x03, then 0x10*0x10) -> 0x0006, then 0x0100; no strobe overlap.
- Timeout (ALU_HOST_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, Done_i forced 0) -> res_valid with res_err=1, res_data=0x0000 after 16 S_WAIT cycles. Without the macro, the FSM stays in S_WAIT.

Source files
------------

// File: rtl/alu_host_seq_pkg.sv
// Shared types and constants for the ALU host sequencer: state encoding,
// command-byte bit positions, transaction size and flags-byte layout.
package alu_host_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_GETA  = 4'd1,
    S_GETB  = 4'd2,
    S_DRVA  = 4'd3,
    S_DRVB  = 4'd4,
    S_DRVC  = 4'd5,
    S_EXEC  = 4'd6,
    S_WAIT  = 4'd7,
    S_CAPHI = 4'd8,
    S_OUT   = 4'd9
  } state_t;

  localparam int CMD_MUL   = 7;
  localparam int CMD_BCD   = 6;
  localparam int CMD_SHR   = 5;
  localparam int CMD_CI    = 4;
  localparam int CMD_OP_HI = 3;
  localparam int CMD_OP_LO = 0;

  localparam int TXN_BYTES = 3;

  // Flags byte is {3'b000, CO, V, Z, N, HC}
  localparam int FLAG_CO = 4;
  localparam int FLAG_V  = 3;
  localparam int FLAG_Z  = 2;
  localparam int FLAG_N  = 1;
  localparam int FLAG_HC = 0;

  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] a;
    logic [7:0] b;
  } txn_t;

endpackage

// File: rtl/alu_host_seq_rx.sv
// Three-byte host collector: gathers Cmd, A, B on a valid/ready byte stream,
// then drops in_ready until the sequencer re-arms it.
module alu_host_seq_rx
  import alu_host_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       rearm,
  output logic       in_ready,
  output logic       accept,
  output logic       cmd_take,
  output logic       txn_go,
  output txn_t       txn
);

  logic [1:0] idx;

  assign accept   = in_valid && in_ready;
  assign cmd_take = accept && (idx == 2'd0);
  assign txn_go   = accept && (idx == 2'(TXN_BYTES - 1));

  // Byte index, held operand registers and the ready flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx      <= 2'd0;
      in_ready <= 1'b1;
      txn      <= '0;
    end else if (accept) begin
      case (idx)
        2'd0: begin
          txn.cmd <= in_data;
          idx     <= 2'd1;
        end
        2'd1: begin
          txn.a <= in_data;
          idx   <= 2'd2;
        end
        2'd2: begin
          txn.b    <= in_data;
          idx      <= 2'd0;
          in_ready <= 1'b0;
        end
        default: idx <= 2'd0;
      endcase
    end else if (rearm) begin
      in_ready <= 1'b1;
    end else begin
      in_ready <= in_ready;
    end
  end

endmodule

// File: rtl/alu_host_seq.sv
// Host sequencer for the 8-bit ALU/multiplier wrapper. Optional Done timeout
// is enabled with `define ALU_HOST_SEQ_TIMEOUT_EN.
module alu_host_seq
  import alu_host_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        res_valid,
  output logic [15:0] res_data,
  output logic        res_err,
  input  logic        res_ready,
  output logic [7:0]  ABCmd_o,
  output logic        LoadA_o,
  output logic        LoadB_o,
  output logic        LoadCmd_o,
  input  logic [7:0]  ACC_i,
  input  logic        Done_i,
  output logic        busy
);

  state_t     state;
  state_t     next_state;
  txn_t       txn;
  logic       accept;
  logic       cmd_take;
  logic       txn_go;
  logic       rearm;
  logic       timeout;
  logic [7:0] abcmd_next;
  logic       load_a_next;
  logic       load_b_next;
  logic       load_cmd_next;

  assign rearm = (state == S_OUT) && res_ready;

  alu_host_seq_rx u_rx (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .rearm    (rearm),
    .in_ready (in_ready),
    .accept   (accept),
    .cmd_take (cmd_take),
    .txn_go   (txn_go),
    .txn      (txn)
  );

`ifdef ALU_HOST_SEQ_TIMEOUT_EN
  logic [15:0] wait_cnt;

  // Cycles spent in S_WAIT; zero on entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= 16'd0;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt + 16'd1;
    end else begin
      wait_cnt <= 16'd0;
    end
  end

  assign timeout = (state == S_WAIT) && !Done_i && (wait_cnt == 16'(TIMEOUT_CYCLES - 1));

  // Error flag: set by timeout, cleared by the next accepted Cmd byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_err <= 1'b0;
    end else if (timeout) begin
      res_err <= 1'b1;
    end else if (cmd_take) begin
      res_err <= 1'b0;
    end else begin
      res_err <= res_err;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
  assign res_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (accept) next_state = S_GETA; else next_state = S_IDLE;
      S_GETA:  if (accept) next_state = S_GETB; else next_state = S_GETA;
      S_GETB:  if (txn_go) next_state = S_DRVA; else next_state = S_GETB;
      S_DRVA:  next_state = S_DRVB;
      S_DRVB:  next_state = S_DRVC;
      S_DRVC:  next_state = S_EXEC;
      S_EXEC:  next_state = S_WAIT;
      S_WAIT: begin
        if (Done_i) begin
          next_state = S_CAPHI;
        end else if (timeout) begin
          next_state = S_OUT;
        end else begin
          next_state = S_WAIT;
        end
      end
      S_CAPHI: next_state = S_OUT;
      S_OUT:   if (res_ready) next_state = S_IDLE; else next_state = S_OUT;
      default: next_state = S_IDLE;
    endcase
  end

  // Wrapper bus values for the state being entered; the bus otherwise holds
  always_comb begin
    abcmd_next    = ABCmd_o;
    load_a_next   = 1'b0;
    load_b_next   = 1'b0;
    load_cmd_next = 1'b0;
    case (next_state)
      S_DRVA: begin
        abcmd_next  = txn.a;
        load_a_next = 1'b1;
      end
      S_DRVB: begin
        abcmd_next  = txn.a;
        load_b_next = 1'b1;
      end
      S_DRVC: begin
        abcmd_next    = txn.b;
        load_cmd_next = 1'b1;
      end
      S_EXEC:  abcmd_next = txn.cmd;
      default: abcmd_next = ABCmd_o;
    endcase
  end

  // Registered wrapper strobes and host status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ABCmd_o   <= 8'h00;
      LoadA_o   <= 1'b0;
      LoadB_o   <= 1'b0;
      LoadCmd_o <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ABCmd_o   <= abcmd_next;
      LoadA_o   <= load_a_next;
      LoadB_o   <= load_b_next;
      LoadCmd_o <= load_cmd_next;
      res_valid <= (next_state == S_OUT);
      busy      <= (next_state != S_IDLE);
    end
  end

  // Result capture: lo with Done, hi one cycle later; held through S_OUT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_data <= 16'h0000;
    end else if ((state == S_WAIT) && Done_i) begin
      res_data[7:0] <= ACC_i;
    end else if (timeout) begin
      res_data <= 16'h0000;
    end else if (state == S_CAPHI) begin
      res_data[15:8] <= ACC_i;
    end else begin
      res_data <= res_data;
    end
  end

endmodule

// File: tb/tb_alu_host_seq.sv
// Directed, table-driven bench for alu_host_seq with a small wrapper stand-in.
module tb_alu_host_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_err;
  logic        res_ready;
  logic [7:0]  ABCmd_o;
  logic        LoadA_o, LoadB_o, LoadCmd_o;
  logic [7:0]  ACC_i;
  logic        Done_i;
  logic        busy;

  int tests = 0;
  int failed = 0;
  int overlaps = 0;
  logic kill_done = 1'b0;

  always #5 clk = ~clk;

  alu_host_seq #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .res_valid(res_valid), .res_data(res_data),
    .res_err(res_err), .res_ready(res_ready), .ABCmd_o(ABCmd_o),
    .LoadA_o(LoadA_o), .LoadB_o(LoadB_o), .LoadCmd_o(LoadCmd_o),
    .ACC_i(ACC_i), .Done_i(Done_i), .busy(busy)
  );

  // Wrapper stand-in: A on LoadB, B on LoadCmd, computes with Cmd on the bus next cycle
  logic [7:0]  w_a, w_b, w_hi;
  logic        w_exec, w_done;
  logic [15:0] w_res;
  assign w_res  = ABCmd_o[7] ? (16'(w_a) * 16'(w_b)) : {8'h00, w_a + w_b};
  assign Done_i = w_done && !kill_done;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      w_a <= 8'h00; w_b <= 8'h00; w_hi <= 8'h00;
      w_exec <= 1'b0; w_done <= 1'b0; ACC_i <= 8'h00;
    end else begin
      if (LoadB_o) w_a <= ABCmd_o;
      if (LoadCmd_o) w_b <= ABCmd_o;
      w_exec <= LoadCmd_o;
      w_done <= 1'b0;
      if (w_exec) begin
        ACC_i  <= w_res[7:0];
        w_hi   <= w_res[15:8];
        w_done <= 1'b1;
      end else if (w_done) begin
        ACC_i <= w_hi;
      end
    end
  end

  always @(negedge clk)
    if ($countones({LoadA_o, LoadB_o, LoadCmd_o}) > 1) overlaps++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap);
    int guard;
    repeat (gap + 1) @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  a;
    logic [7:0]  b;
    int          gap;
    int          hold;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[6];
  int   lat;
  logic stable;
  logic [15:0] first;

  initial begin
    vecs[0] = '{8'h80, 8'h0C, 8'h0A, 0, 0, 16'h0078};
    vecs[1] = '{8'h80, 8'hFF, 8'hFF, 0, 0, 16'hFE01};
    vecs[2] = '{8'h80, 8'h07, 8'h09, 3, 5, 16'h003F};
    vecs[3] = '{8'h80, 8'h02, 8'h03, 0, 0, 16'h0006};
    vecs[4] = '{8'h80, 8'h10, 8'h10, 0, 0, 16'h0100};
    vecs[5] = '{8'h80, 8'h01, 8'h80, 1, 2, 16'h0080};

    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_outputs", {ABCmd_o, LoadA_o, LoadB_o, LoadCmd_o, res_valid, res_err, busy}, 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    @(negedge clk) reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      send_byte(vecs[v].cmd, vecs[v].gap);
      send_byte(vecs[v].a, vecs[v].gap);
      send_byte(vecs[v].b, vecs[v].gap);
      // cycle 1 is the one opened by the edge accepting B
      lat = 1;
      while (!res_valid && lat < 60) begin
        if (v == 0 && lat <= 4) begin
          case (lat)
            1: chk("bus_c1", {ABCmd_o, LoadA_o, LoadB_o, LoadCmd_o}, {8'h0C, 3'b100});
            2: chk("bus_c2", {ABCmd_o, LoadA_o, LoadB_o, LoadCmd_o}, {8'h0C, 3'b010});
            3: chk("bus_c3", {ABCmd_o, LoadA_o, LoadB_o, LoadCmd_o}, {8'h0A, 3'b001});
            default: chk("bus_c4", {ABCmd_o, LoadA_o, LoadB_o, LoadCmd_o}, {8'h80, 3'b000});
          endcase
        end
        if (lat == 2) chk("in_ready_busy", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        lat++;
      end
      chk($sformatf("latency_v%0d", v), lat, 7);
      chk($sformatf("res_data_v%0d", v), 32'(res_data), 32'(vecs[v].exp));
      chk($sformatf("res_err_v%0d", v), 32'(res_err), 32'd0);
      first  = res_data;
      stable = 1'b1;
      for (int h = 0; h < vecs[v].hold; h++) begin
        @(posedge clk);
        #1;
        if (res_data !== first || !res_valid || in_ready) stable = 1'b0;
      end
      if (vecs[v].hold > 0) chk($sformatf("hold_v%0d", v), 32'(stable), 32'd1);
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      chk($sformatf("release_v%0d", v), {res_valid, in_ready, busy}, {1'b0, 1'b1, 1'b0});
      chk($sformatf("bus_hold_v%0d", v), 32'(ABCmd_o), 32'h80);
    end

    // Reset in the middle of S_DRVB
    send_byte(8'h80, 0);
    send_byte(8'h05, 0);
    send_byte(8'h06, 0);
    @(posedge clk);
    #1;
    chk("drvb_strobe", {LoadA_o, LoadB_o, LoadCmd_o}, 32'b010);
    #2 reset = 1'b1;
    #1;
    chk("midrst_outputs", {ABCmd_o, LoadA_o, LoadB_o, LoadCmd_o, res_valid, busy}, 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk) reset = 1'b0;

    // Done never arrives
    kill_done = 1'b1;
    send_byte(8'h80, 0);
    send_byte(8'h03, 0);
    send_byte(8'h03, 0);
    lat = 1;
    while (!res_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    kill_done = 1'b0;
`ifdef ALU_HOST_SEQ_TIMEOUT_EN
    chk("to_latency", lat, 21);
    chk("to_err", 32'(res_err), 32'd1);
    chk("to_data", 32'(res_data), 32'd0);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
`else
    chk("to_stuck", {res_valid, busy, in_ready}, {1'b0, 1'b1, 1'b0});
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
`endif
    send_byte(8'h80, 0);
    chk("err_cleared", 32'(res_err), 32'd0);
    send_byte(8'h11, 0);
    send_byte(8'h02, 0);
    lat = 1;
    while (!res_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("after_to_data", 32'(res_data), 32'h0022);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;

    chk("strobe_overlap", overlaps, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
